// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//
// Shared definitions for the load/store initiator:
//   - access size encodings as they arrive on req_size
//   - FSM state enumeration used by lsu_master
//   - lane masks that describe how many bits a sub-word access touches
//   - small helpers for size normalisation and alignment checks
//
// No ports; imported by lsu_master and lsu_lane_align.
// ---------------------------------------------------------------------------
package lsu_pkg;

    // Access size encodings. The fourth code is reserved and behaves as a word.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;

    // Right-justified lane masks, shifted into place by the byte offset.
    localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;
    localparam logic [31:0] LANE_MASK_W = 32'hFFFF_FFFF;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } state_t;

    // Fold the reserved size code onto a plain word so everything downstream
    // only ever sees three sizes.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == SIZE_R) ? SIZE_W : size;
    endfunction

    // True when the byte offset does not sit on the natural boundary of the
    // access size. Bytes can never be misaligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

    // Right-justified mask for an access of the given (normalised) size.
    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        logic [31:0] m;
        case (size)
            SIZE_B:  m = LANE_MASK_B;
            SIZE_H:  m = LANE_MASK_H;
            default: m = LANE_MASK_W;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
//
// Purely combinational byte-lane steering for the load/store initiator.
//   Store side: merges right-justified store data into an existing memory
//   word at the lane(s) selected by size and byte offset (little-endian,
//   byte 0 = bits [7:0]). A word access replaces the whole word.
//   Load side: pulls the addressed byte/half out of a memory word and sign-
//   or zero-extends it; words pass through unchanged.
//
// Ports:
//   old_word    in  32  word previously read from memory
//   wdata       in  32  store data, right-justified
//   size        in  2   normalised access size (byte/half/word)
//   offset      in  2   byte offset within the word (already aligned)
//   is_unsigned in  1   zero-extend loads when set
//   merged      out 32  word to be written back for a store
//   extracted   out 32  extended load result
// ---------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [4:0]  shamt;
    logic [31:0] base_mask;
    logic [31:0] placed_mask;
    logic [31:0] shifted;

    assign shamt = {offset, 3'b000};

    // Store merge: clear the target lanes in the old word, then OR in the
    // store data after trimming it to the access width and moving it to the
    // addressed lane. For a word the mask is all ones and the shift is zero,
    // so the result is simply the store data.
    always_comb begin
        base_mask   = lane_mask(size);
        placed_mask = base_mask << shamt;
        merged      = (old_word & ~placed_mask) | ((wdata & base_mask) << shamt);
    end

    // Load extract: bring the addressed lane down to bit 0, then extend.
    // Sign extension is suppressed by is_unsigned; words ignore it.
    always_comb begin
        shifted = old_word >> shamt;
        case (size)
            SIZE_B:  extracted = {{24{~is_unsigned & shifted[7]}},  shifted[7:0]};
            SIZE_H:  extracted = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: extracted = old_word;
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// ---------------------------------------------------------------------------
// lsu_master
//
// Load/store initiator for the multicycle core. Takes one load or store
// command at a time from execute and drives a word-wide data memory with a
// combinational read port. Sub-word stores are done as read-modify-write
// because the memory only writes whole 32-bit words.
//
// Latency from the accepting edge to the rsp_valid cycle:
//   fault 1, load 2, word store 2, byte/half store 3.
// A command is only accepted in IDLE, so back-to-back commands always see
// one IDLE cycle between them.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   -> misaligned accesses complete with
//                                      rsp_fault=1 and never touch memory
//                         undefined -> rsp_fault is 0, the address is forced
//                                      to natural alignment and the access
//                                      proceeds normally
//
// Ports:
//   clock          in   1       system clock, rising edge
//   reset          in   1       asynchronous active-high reset
//   req_valid      in   1       command present
//   req_ready      out  1       command accepted when valid & ready
//   req_write      in   1       1 = store, 0 = load
//   req_size       in   2       00 byte, 01 half, 10 word, 11 treated as word
//   req_unsigned   in   1       zero-extend loads
//   req_addr       in   ADDR_W  byte address
//   req_wdata      in   32      store data, right-justified
//   rsp_valid      out  1       single-cycle completion pulse
//   rsp_rdata      out  32      extended load data, 0 for stores and faults
//   rsp_fault      out  1       misaligned access, valid with rsp_valid
//   mem_address    out  ADDR_W  word-aligned byte address
//   mem_writeInput out  32      full word to write
//   mem_Wmem       out  1       memory write enable
//   mem_Dout       in   32      combinational read data for mem_address
// ---------------------------------------------------------------------------
module lsu_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writeInput,
    output logic              mem_Wmem,
    input  logic [31:0]       mem_Dout
);

    state_t            state_q;
    state_t            state_d;

    logic              write_q;
    logic              unsigned_q;
    logic              fault_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;

    logic              accept;
    logic [1:0]        req_size_n;
    logic              req_fault;
    logic [ADDR_W-1:0] req_addr_eff;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       merged_word;
    logic [31:0]       load_value;

    assign accept     = req_valid && (state_q == IDLE);
    assign req_size_n = norm_size(req_size);
    assign word_addr  = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned commands are flagged at accept time and short-circuit to
    // RESP; the address is kept as given so the fault is reported faithfully.
    assign req_fault    = is_misaligned(req_size_n, req_addr[1:0]);
    assign req_addr_eff = req_addr;
`else
    // Without trapping, misaligned commands are silently rounded down to
    // their natural boundary and run like any aligned access.
    assign req_fault = 1'b0;

    always_comb begin
        req_addr_eff = req_addr;
        if (req_size_n == SIZE_H) begin
            req_addr_eff[0] = 1'b0;
        end else if (req_size_n == SIZE_W) begin
            req_addr_eff[1:0] = 2'b00;
        end
    end
`endif

    // Lane steering lives in its own block: merge for the WRITE cycle of a
    // store, extract/extend for the RESP cycle of a load. Both work from the
    // word captured in data_q, so nothing here depends on live memory data.
    lsu_lane_align u_lane_align (
        .old_word    (data_q),
        .wdata       (wdata_q),
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (unsigned_q),
        .merged      (merged_word),
        .extracted   (load_value)
    );

    // State register. Reset is asynchronous so an in-flight store is
    // abandoned the moment reset rises; mem_Wmem is decoded from state and
    // therefore drops in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command and data registers. The whole command is captured on accept so
    // the requester is free to change its inputs while we work. The memory
    // word is captured at the end of LOAD (for the load result) and at the
    // end of RMW_READ (as the base for the sub-word merge).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            fault_q    <= 1'b0;
            size_q     <= SIZE_B;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
        end else begin
            if (accept) begin
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                fault_q    <= req_fault;
                size_q     <= req_size_n;
                addr_q     <= req_addr_eff;
                wdata_q    <= req_wdata;
            end
            if ((state_q == LOAD) || (state_q == RMW_READ)) begin
                data_q <= mem_Dout;
            end
        end
    end

    // Next-state and output decode. Every output defaults to its idle value
    // so the memory bus reads as zero outside the three memory states, and
    // the response bus reads as zero outside RESP.
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_rdata      = '0;
        rsp_fault      = 1'b0;
        mem_address    = '0;
        mem_writeInput = '0;
        mem_Wmem       = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fault) begin
                        state_d = RESP;
                    end else if (!req_write) begin
                        state_d = LOAD;
                    end else if (req_size_n == SIZE_W) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_READ;
                    end
                end
            end

            LOAD: begin
                mem_address = word_addr;
                state_d     = RESP;
            end

            RMW_READ: begin
                mem_address = word_addr;
                state_d     = WRITE;
            end

            WRITE: begin
                mem_address    = word_addr;
                mem_writeInput = merged_word;
                mem_Wmem       = 1'b1;
                state_d        = RESP;
            end

            RESP: begin
                rsp_valid = 1'b1;
                if (!write_q && !fault_q) begin
                    rsp_rdata = load_value;
                end
`ifdef LSU_MISALIGN_TRAP_EN
                rsp_fault = fault_q;
`endif
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_master
//
// Self-checking bench for lsu_master. A small word-wide memory model sits on
// the mem_* port. Each command pushes its expected response (data, fault,
// latency, write-pulse count) onto a scoreboard queue and the response is
// popped and compared when rsp_valid is seen. Expectations follow the
// LSU_MISALIGN_TRAP_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_lsu_master;

    localparam int ADDR_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_writeInput;
    logic              mem_Wmem;
    logic [31:0]       mem_Dout;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          latency;
        int          wpulses;
    } exp_t;

    exp_t sb_q[$];

    // Memory model: 64 words covering byte addresses 0x00-0xFF. Preloads go
    // through the same clocked process as DUT writes.
    logic [31:0] mem [0:63];
    logic        pre_en;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    always #5 clock = ~clock;

    assign mem_Dout = mem[mem_address[7:2]];

    always @(posedge clock) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_data;
        end else if (mem_Wmem) begin
            mem[mem_address[7:2]] <= mem_writeInput;
        end
    end

    lsu_master #(.ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_fault      (rsp_fault),
        .mem_address    (mem_address),
        .mem_writeInput (mem_writeInput),
        .mem_Wmem       (mem_Wmem),
        .mem_Dout       (mem_Dout)
    );

    // Reference load extraction written lane by lane.
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        if (sz == 2'b00)      return uns ? {24'h0, b} : {{24{b[7]}}, b};
        else if (sz == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
        else                  return w;
    endfunction

    task automatic preload(input logic [5:0] idx, input logic [31:0] d);
        @(negedge clock);
        pre_en   = 1'b1;
        pre_idx  = idx;
        pre_data = d;
        @(negedge clock);
        pre_en   = 1'b0;
    endtask

    // Issue one command from an IDLE cycle, push its expectation, then watch
    // up to eight cycles for the response and compare against the scoreboard.
    task automatic run_cmd(input string name, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        exp_t        got;
        logic [31:0] ea;
        int          lat;
        int          wp;
        bit          seen;
        ea = addr;
`ifdef LSU_MISALIGN_TRAP_EN
        e.fault = (sz == 2'b01) ? addr[0] : ((sz[1]) ? (addr[1:0] != 2'b00) : 1'b0);
`else
        e.fault = 1'b0;
        if (sz == 2'b01) ea[0] = 1'b0;
        else if (sz[1])  ea[1:0] = 2'b00;
`endif
        e.rdata   = (wr || e.fault) ? 32'h0 : model_load(mem[ea[7:2]], sz, uns, ea[1:0]);
        e.latency = e.fault ? 1 : (!wr ? 2 : ((sz == 2'b00 || sz == 2'b01) ? 3 : 2));
        e.wpulses = (wr && !e.fault) ? 1 : 0;
        sb_q.push_back(e);

        @(negedge clock);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s ready: got %b expected 1", name, req_ready);
        end
        @(posedge clock);
        lat  = 0;
        wp   = 0;
        seen = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clock);
            if (c == 1) req_valid = 1'b0;
            if (mem_Wmem === 1'b1) wp++;
            if (rsp_valid === 1'b1) begin
                seen = 1;
                lat  = c;
                got.rdata = rsp_rdata;
                got.fault = rsp_fault;
            end
        end
        e = sb_q.pop_front();
        checks++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL %s timeout: no rsp_valid within 8 cycles, expected latency %0d", name, e.latency);
        end else begin
            if (got.rdata !== e.rdata) begin
                fails++;
                $display("[TB] FAIL %s rdata: got %h expected %h", name, got.rdata, e.rdata);
            end
            checks++;
            if (got.fault !== e.fault) begin
                fails++;
                $display("[TB] FAIL %s fault: got %b expected %b", name, got.fault, e.fault);
            end
            checks++;
            if (lat != e.latency) begin
                fails++;
                $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, e.latency);
            end
            checks++;
            if (wp != e.wpulses) begin
                fails++;
                $display("[TB] FAIL %s write pulses: got %0d expected %0d", name, wp, e.wpulses);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks += 7;
        if (req_ready !== 1'b1)        begin fails++; $display("[TB] FAIL reset ready: got %b expected 1", req_ready); end
        if (rsp_valid !== 1'b0)        begin fails++; $display("[TB] FAIL reset rsp_valid: got %b expected 0", rsp_valid); end
        if (rsp_rdata !== 32'h0)       begin fails++; $display("[TB] FAIL reset rsp_rdata: got %h expected 0", rsp_rdata); end
        if (rsp_fault !== 1'b0)        begin fails++; $display("[TB] FAIL reset rsp_fault: got %b expected 0", rsp_fault); end
        if (mem_address !== '0)        begin fails++; $display("[TB] FAIL reset mem_address: got %h expected 0", mem_address); end
        if (mem_writeInput !== 32'h0)  begin fails++; $display("[TB] FAIL reset mem_writeInput: got %h expected 0", mem_writeInput); end
        if (mem_Wmem !== 1'b0)         begin fails++; $display("[TB] FAIL reset mem_Wmem: got %b expected 0", mem_Wmem); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_word();
        run_cmd("sw 40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
        checks++;
        if (mem[16] !== 32'hDEADBEEF) begin
            fails++;
            $display("[TB] FAIL sw 40 memory: got %h expected deadbeef", mem[16]);
        end
        run_cmd("lw 40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic test_subword_store();
        preload(6'h20, 32'h11223344);
        run_cmd("sb 81", 1'b1, 2'b00, 1'b0, 32'h81, 32'hFFFFFFAA);
        checks++;
        if (mem[32] !== 32'h1122AA44) begin
            fails++;
            $display("[TB] FAIL sb 81 memory: got %h expected 1122aa44", mem[32]);
        end
        run_cmd("sh 82", 1'b1, 2'b01, 1'b0, 32'h82, 32'h5555BEEF);
        checks++;
        if (mem[32] !== 32'hBEEFAA44) begin
            fails++;
            $display("[TB] FAIL sh 82 memory: got %h expected beefaa44", mem[32]);
        end
    endtask

    task automatic test_load_ext();
        preload(6'h20, 32'h80FF7F01);
        run_cmd("lb 82",  1'b0, 2'b00, 1'b0, 32'h82, 32'h0);
        run_cmd("lbu 82", 1'b0, 2'b00, 1'b1, 32'h82, 32'h0);
        run_cmd("lh 82",  1'b0, 2'b01, 1'b0, 32'h82, 32'h0);
        run_cmd("lhu 80", 1'b0, 2'b01, 1'b1, 32'h80, 32'h0);
        run_cmd("lb 83",  1'b0, 2'b00, 1'b0, 32'h83, 32'h0);
        run_cmd("lb 80",  1'b0, 2'b00, 1'b0, 32'h80, 32'h0);
        run_cmd("lwu 80", 1'b0, 2'b10, 1'b1, 32'h80, 32'h0);
        run_cmd("lrsv 80", 1'b0, 2'b11, 1'b0, 32'h80, 32'h0);
    endtask

    task automatic test_misalign();
        logic [31:0] exp_word;
        run_cmd("lw 42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0);
        run_cmd("sh 43", 1'b1, 2'b01, 1'b0, 32'h43, 32'h00001234);
`ifdef LSU_MISALIGN_TRAP_EN
        exp_word = 32'hDEADBEEF;
`else
        exp_word = 32'h1234BEEF;
`endif
        checks++;
        if (mem[16] !== exp_word) begin
            fails++;
            $display("[TB] FAIL sh 43 memory: got %h expected %h", mem[16], exp_word);
        end
    endtask

    task automatic test_reset_mid();
        int rsp_seen;
        preload(6'h20, 32'h11223344);
        @(negedge clock);
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h81;
        req_wdata    = 32'h000000AA;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (mem_Wmem !== 1'b0) begin fails++; $display("[TB] FAIL rmw read wmem: got %b expected 0", mem_Wmem); end
        @(negedge clock);
        checks++;
        if (mem_Wmem !== 1'b1) begin fails++; $display("[TB] FAIL rmw write wmem: got %b expected 1", mem_Wmem); end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_Wmem !== 1'b0) begin fails++; $display("[TB] FAIL abort wmem: got %b expected 0", mem_Wmem); end
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (mem[32] !== 32'h11223344) begin fails++; $display("[TB] FAIL abort memory: got %h expected 11223344", mem[32]); end
        checks++;
        if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL abort ready: got %b expected 1", req_ready); end
        rsp_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0) rsp_seen++;
        end
        checks++;
        if (rsp_seen != 0) begin fails++; $display("[TB] FAIL abort rsp_valid: got %0d pulses expected 0", rsp_seen); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   rsp_cycles[$];
        int   wcnt;
        int   wcyc;
        int   acc_cycle;
        e.rdata = mem[16]; e.fault = 1'b0; e.latency = 2; e.wpulses = 0;
        sb_q.push_back(e);
        e.rdata = 32'h0;   e.latency = 2; e.wpulses = 1;
        sb_q.push_back(e);
        @(negedge clock);
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h40;
        req_wdata    = 32'h0;
        @(posedge clock);
        wcnt = 0; wcyc = 0; acc_cycle = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 1) begin
                req_write = 1'b1;
                req_addr  = 32'h44;
                req_wdata = 32'hCAFEF00D;
            end
            if (mem_Wmem === 1'b1) begin wcnt++; wcyc = c; end
            if (rsp_valid === 1'b1) begin
                rsp_cycles.push_back(c);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    checks++;
                    if (rsp_rdata !== e.rdata) begin
                        fails++;
                        $display("[TB] FAIL b2b rdata at cycle %0d: got %h expected %h", c, rsp_rdata, e.rdata);
                    end
                end
            end
            if (acc_cycle != 0 && c == acc_cycle + 1) req_valid = 1'b0;
            if (req_ready === 1'b1 && req_valid && acc_cycle == 0) acc_cycle = c;
        end
        req_valid = 1'b0;
        checks++;
        if (acc_cycle != 3) begin fails++; $display("[TB] FAIL b2b accept cycle: got %0d expected 3", acc_cycle); end
        checks++;
        if (rsp_cycles.size() != 2 || rsp_cycles[0] != 2 || rsp_cycles[1] != 5) begin
            fails++;
            $display("[TB] FAIL b2b responses: got %0d pulses expected 2 at cycles 2 and 5", rsp_cycles.size());
        end
        checks++;
        if (wcnt != 1 || wcyc != 4) begin
            fails++;
            $display("[TB] FAIL b2b write: got %0d pulses at cycle %0d expected 1 at cycle 4", wcnt, wcyc);
        end
        checks++;
        if (mem[17] !== 32'hCAFEF00D) begin
            fails++;
            $display("[TB] FAIL b2b memory: got %h expected cafef00d", mem[17]);
        end
    endtask

    // Hard stop in case a task gets wedged.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        pre_en       = 1'b0;
        pre_idx      = '0;
        pre_data     = '0;
        test_reset();
        test_word();
        test_subword_store();
        test_load_ext();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
